// File: rtl/ii_pkg.sv
// Shared types and helpers for the integral-image server.
// State encoding, image-size helper and default widths.
package ii_pkg;

    localparam int W_PIX_DEF  = 8;
    localparam int IMG_W_DEF  = 25;
    localparam int IMG_H_DEF  = 25;
    localparam int W_DATA_DEF = 18;
    localparam int W_ADDR_DEF = 10;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SERVE,
        ST_DRAIN
    } state_e;

    typedef logic [W_ADDR_DEF-1:0] addr_t;
    typedef logic [W_DATA_DEF-1:0] data_t;

    function automatic int img_size(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/ii_ram.sv
// Single-port synchronous RAM holding the summed-area table.
// Registered read: data appears the cycle after re.
module ii_ram #(
    parameter int DEPTH = 625,
    parameter int W_A   = 10,
    parameter int W_D   = 18
) (
    input  logic           clk,
    input  logic           we,
    input  logic           re,
    input  logic [W_A-1:0] addr,
    input  logic [W_D-1:0] wdata,
    output logic [W_D-1:0] rdata
);

    logic [W_D-1:0] mem [DEPTH];
    logic [W_D-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/integral_image_server.sv
// Builds the integral image from a raster pixel stream into RAM,
// then answers single-word read requests over valid/ready channels.
import ii_pkg::*;

module integral_image_server #(
    parameter int W_PIX      = W_PIX_DEF,
    parameter int IMG_WIDTH  = IMG_W_DEF,
    parameter int IMG_HEIGHT = IMG_H_DEF,
    parameter int W_DATA     = W_DATA_DEF,
    parameter int W_ADDR     = W_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [W_PIX-1:0]  pix_data,
    input  logic              addr_valid,
    output logic              addr_ready,
    input  logic [W_ADDR-1:0] addr_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [W_DATA-1:0] dout_data,
    input  logic              img_release,
    output logic              img_ready,
    output logic              addr_err
);

    localparam int IMG_SIZE = img_size(IMG_WIDTH, IMG_HEIGHT);
    localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int AI = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [W_ADDR:0] SIZE_A = (W_ADDR + 1)'(IMG_SIZE);

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [AI-1:0]     lin_q, lin_d;
    logic [W_DATA-1:0] row_acc_q, row_acc_d;
    logic [W_DATA-1:0] line_buf_q [IMG_WIDTH];
    logic [W_DATA-1:0] line_buf_d [IMG_WIDTH];
    logic              dout_valid_q, dout_valid_d;
    logic              oor_q, oor_d;
    logic              addr_err_q, addr_err_d;

    logic              ram_we, ram_re;
    logic [AI-1:0]     ram_addr;
    logic [W_DATA-1:0] ram_rdata;
    logic [W_DATA-1:0] row_new, ii_val;
    logic              addr_oor;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        lin_d        = lin_q;
        row_acc_d    = row_acc_q;
        line_buf_d   = line_buf_q;
        dout_valid_d = dout_valid_q;
        oor_d        = oor_q;
        addr_err_d   = addr_err_q;
        pix_ready    = 1'b0;
        addr_ready   = 1'b0;
        img_ready    = 1'b0;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_addr     = lin_q;

        row_new  = ((x_q == '0) ? '0 : row_acc_q) + W_DATA'(pix_data);
        ii_val   = row_new + ((y_q == '0) ? '0 : line_buf_q[x_q]);
        addr_oor = ({1'b0, addr_data} >= SIZE_A);

        case (state_q)
            ST_LOAD: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    ram_we           = 1'b1;
                    row_acc_d        = row_new;
                    line_buf_d[x_q]  = ii_val;
                    lin_d            = lin_q + 1'b1;
                    x_d              = x_q + 1'b1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            lin_d   = '0;
                            state_d = ST_SERVE;
                        end
                    end
                end
            end
            ST_SERVE: begin
                img_ready  = 1'b1;
                addr_ready = !dout_valid_q || dout_ready;
                if (dout_ready) begin
                    dout_valid_d = 1'b0;
                end
                // Out-of-range requests still occupy a response slot.
                if (addr_valid && addr_ready) begin
                    ram_re       = !addr_oor;
                    ram_addr     = addr_data[AI-1:0];
                    dout_valid_d = 1'b1;
                    oor_d        = addr_oor;
                    if (addr_oor) begin
                        addr_err_d = 1'b1;
                    end
                end
                if (img_release) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dout_ready) begin
                    dout_valid_d = 1'b0;
                end
                if (!dout_valid_q) begin
                    state_d    = ST_LOAD;
                    addr_err_d = 1'b0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            x_q          <= '0;
            y_q          <= '0;
            lin_q        <= '0;
            row_acc_q    <= '0;
            dout_valid_q <= 1'b0;
            oor_q        <= 1'b0;
            addr_err_q   <= 1'b0;
            for (int i = 0; i < IMG_WIDTH; i++) begin
                line_buf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            lin_q        <= lin_d;
            row_acc_q    <= row_acc_d;
            dout_valid_q <= dout_valid_d;
            oor_q        <= oor_d;
            addr_err_q   <= addr_err_d;
            line_buf_q   <= line_buf_d;
        end
    end

    ii_ram #(
        .DEPTH(IMG_SIZE),
        .W_A  (AI),
        .W_D  (W_DATA)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(ii_val),
        .rdata(ram_rdata)
    );

    assign dout_valid = dout_valid_q;
    assign dout_data  = (dout_valid_q && !oor_q) ? ram_rdata : '0;
    assign addr_err   = addr_err_q;

endmodule
